// File: rtl/mux_rr_sched.sv
// rtl/mux_rr_sched.sv - round-robin scheduler steering a 32:1 mux select and capturing its output as a stream
// Optional feature: define MUX_RR_PRIO0_EN to give channel 0 absolute priority over the round robin.
module mux_rr_sched #(
   parameter int NUM_CH = 30,
   parameter int SEL_W  = 5,
   parameter int DATA_W = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [NUM_CH-1:0] i_req,
   output logic [NUM_CH-1:0] o_ack,
   output logic [SEL_W-1:0]  o_mux_sel,
   input  logic [DATA_W-1:0] i_mux_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic [SEL_W-1:0]  o_out_ch
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_SEND   = 2'd2;

   logic [1:0]       r_state;
   logic [SEL_W-1:0] r_ptr;
   logic [SEL_W-1:0] w_win;
   logic [SEL_W-1:0] w_next_ptr;
   logic             w_any;

   assign w_any = |i_req;

   // First set request at or after r_ptr, wrapping at NUM_CH-1.
   always_comb begin : p_arb
      logic             found;
      logic [SEL_W-1:0] idx;
      int               k;
      w_win = r_ptr;
      found = 1'b0;
      idx   = '0;
      k     = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         k = int'(r_ptr) + i;
         if (k >= NUM_CH) k = k - NUM_CH;
         idx = SEL_W'(k);
         if (!found && i_req[idx]) begin
            w_win = idx;
            found = 1'b1;
         end
      end
`ifdef MUX_RR_PRIO0_EN
      if (i_req[0]) w_win = '0;
`endif
   end

`ifdef MUX_RR_PRIO0_EN
   assign w_next_ptr = (o_mux_sel == '0) ? r_ptr :
                       (o_mux_sel == SEL_W'(NUM_CH - 1)) ? '0 : o_mux_sel + 1'b1;
`else
   assign w_next_ptr = (o_mux_sel == SEL_W'(NUM_CH - 1)) ? '0 : o_mux_sel + 1'b1;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         o_mux_sel   <= '0;
         o_ack       <= '0;
         o_out_valid <= 1'b0;
         o_out_data  <= '0;
         o_out_ch    <= '0;
      end else begin
         o_ack <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  o_mux_sel <= w_win;
                  r_state   <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               o_out_data  <= i_mux_data;
               o_out_ch    <= o_mux_sel;
               o_out_valid <= 1'b1;
               o_ack       <= NUM_CH'(1) << o_mux_sel;
               r_ptr       <= w_next_ptr;
               r_state     <= ST_SEND;
            end
            ST_SEND: begin
               if (o_out_valid && i_out_ready) begin
                  o_out_valid <= 1'b0;
                  if (w_any) begin
                     o_mux_sel <= w_win;
                     r_state   <= ST_SETTLE;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_rr_sched.sv
// tb/tb_mux_rr_sched.sv - self-checking bench for mux_rr_sched against a round-robin reference model
module tb_mux_rr_sched;

   localparam int N = 30;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  i_req;
   logic [N-1:0]  o_ack;
   logic [4:0]    o_mux_sel;
   logic [1:0]    w_mux_data;
   logic          o_out_valid;
   logic          i_out_ready;
   logic [1:0]    o_out_data;
   logic [4:0]    o_out_ch;
   logic [1:0]    tbl [32];

   int n_tests = 0;
   int n_fail  = 0;
   int m_ptr   = 0;

   always #5 clk = ~clk;

   assign w_mux_data = tbl[o_mux_sel];

   mux_rr_sched dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req       (i_req),
      .o_ack       (o_ack),
      .o_mux_sel   (o_mux_sel),
      .i_mux_data  (w_mux_data),
      .o_out_valid (o_out_valid),
      .i_out_ready (i_out_ready),
      .o_out_data  (o_out_data),
      .o_out_ch    (o_out_ch)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef MUX_RR_PRIO0_EN
      if (r[0]) return 0;
`endif
      for (int i = 0; i < N; i++)
         if (r[(p + i) % N]) return (p + i) % N;
      return -1;
   endfunction

   function automatic int advance(input int w, input int p);
`ifdef MUX_RR_PRIO0_EN
      if (w == 0) return p;
`endif
      return (w + 1) % N;
   endfunction

   function automatic logic [N-1:0] rnd_nz();
      logic [31:0] v;
      v = $urandom & $urandom;
      if (v[N-1:0] == '0) v[$urandom_range(0, N-1)] = 1'b1;
      return v[N-1:0];
   endfunction

   task automatic chk_item(input string tag, input int w, input bit first);
      logic [31:0] eack;
      eack = first ? (32'd1 << w) : 32'd0;
      chk({tag, "_valid"}, o_out_valid, 1);
      chk({tag, "_ch"},    o_out_ch, w);
      chk({tag, "_data"},  o_out_data, tbl[w]);
      chk({tag, "_ack"},   o_ack, eack);
      chk({tag, "_sel"},   o_mux_sel, w);
   endtask

   // One item from IDLE: request, optional stall in SEND, then handshake with no requests left.
   task automatic one_from_idle(input string tag, input logic [N-1:0] r, input int w, input int stall);
      @(negedge clk);
      i_req = r;
      i_out_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_arb_sel"}, o_mux_sel, w);
      chk({tag, "_arb_valid"}, o_out_valid, 0);
      @(negedge clk);
      chk_item(tag, w, 1'b1);
      m_ptr = advance(w, m_ptr);
      i_req = '0;
      repeat (stall) begin
         @(negedge clk);
         chk_item({tag, "_hold"}, w, 1'b0);
      end
      i_out_ready = 1'b1;
      @(negedge clk);
      i_out_ready = 1'b0;
      chk({tag, "_done_valid"}, o_out_valid, 0);
      chk({tag, "_done_ack"}, o_ack, 0);
   endtask

   initial begin
      logic [N-1:0] r;
      logic [N-1:0] nr;
      int           w;

      for (int i = 0; i < 32; i++) tbl[i] = 2'($urandom);
      tbl[5] = 2'b10;
      rst_n = 1'b0;
      i_req = '0;
      i_out_ready = 1'b0;

      @(negedge clk);
      chk("rst_valid", o_out_valid, 0);
      chk("rst_sel", o_mux_sel, 0);
      chk("rst_ack", o_ack, 0);
      chk("rst_data", o_out_data, 0);
      chk("rst_ch", o_out_ch, 0);
      rst_n = 1'b1;
      m_ptr = 0;

      one_from_idle("single5", N'(1) << 5, 5, 5);
      chk("single5_tbl_value", o_out_data, 2'b10);

      // Wrap: bring ptr to 29, then {3,29} -> 29 (ptr 0), {3,5} -> 3 (ptr 4), {3,5} -> 5.
      one_from_idle("pre_wrap", N'(1) << 28, 28, 0);
      one_from_idle("wrap29", (N'(1) << 3) | (N'(1) << 29), 29, 1);
      one_from_idle("wrap3", (N'(1) << 3) | (N'(1) << 5), 3, 0);
      one_from_idle("wrap5", (N'(1) << 3) | (N'(1) << 5), 5, 0);

`ifdef MUX_RR_PRIO0_EN
      one_from_idle("pre_prio", N'(1) << 9, 9, 0);
      one_from_idle("prio0", (N'(1) << 0) | (N'(1) << 12), 0, 0);
      one_from_idle("prio12", (N'(1) << 5) | (N'(1) << 12), 12, 0);
`endif

      // Randomised back-to-back traffic with random stalls and idle gaps.
      r = rnd_nz();
      w = pick(r, m_ptr);
      @(negedge clk);
      i_req = r;
      i_out_ready = 1'b0;
      @(negedge clk);
      chk("rnd_first_sel", o_mux_sel, w);
      for (int it = 0; it < 60; it++) begin
         @(negedge clk);
         chk_item("rnd", w, 1'b1);
         m_ptr = advance(w, m_ptr);
         nr = ($urandom_range(0, 4) == 0) ? '0 : rnd_nz();
         i_req = nr;
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            chk_item("rnd_hold", w, 1'b0);
         end
         i_out_ready = 1'b1;
         @(negedge clk);
         i_out_ready = 1'b0;
         chk("rnd_hs_valid", o_out_valid, 0);
         if (nr == '0) begin
            nr = rnd_nz();
            i_req = nr;
            @(negedge clk);
         end
         w = pick(nr, m_ptr);
         chk("rnd_sel", o_mux_sel, w);
      end
      @(negedge clk);
      chk_item("rnd_last", w, 1'b1);
      i_req = '0;

      // Asynchronous reset in the middle of SEND.
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", o_out_valid, 0);
      chk("mid_rst_sel", o_mux_sel, 0);
      chk("mid_rst_ack", o_ack, 0);
      chk("mid_rst_data", o_out_data, 0);
      chk("mid_rst_ch", o_out_ch, 0);
      @(negedge clk);
      rst_n = 1'b1;
      m_ptr = 0;
      @(negedge clk);
      chk("post_rst_valid", o_out_valid, 0);

      // Full load: every channel requesting, ready held high, one item per two cycles.
      i_req = '1;
      i_out_ready = 1'b1;
      for (int k = 0; k <= N; k++) begin
         w = pick('1, m_ptr);
         @(negedge clk);
         chk("full_gap_valid", o_out_valid, 0);
         chk("full_sel", o_mux_sel, w);
         @(negedge clk);
         chk_item("full", w, 1'b1);
         m_ptr = advance(w, m_ptr);
      end
`ifndef MUX_RR_PRIO0_EN
      chk("full_wrapped_to_0", o_out_ch, 0);
`endif
      i_req = '0;
      @(negedge clk);
      chk("full_end_valid", o_out_valid, 0);
      i_out_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
